// File: rtl/core_seq_pkg.sv
// Shared types and constants for the mspu core sequencer.
package core_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB
   } seq_state_t;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/core_seq_if.sv
// Instruction/data memory request-acknowledge bundle driven by core_sequencer (master).
interface core_seq_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;
   logic              dmem_req;
   logic              dmem_we;
   logic              dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/core_seq_perf.sv
// Cycle and retired-instruction counters for core_sequencer; both wrap at 2^64.
module core_seq_perf (
   input  logic        clk,
   input  logic        reset,
   input  logic        busy_i,
   input  logic        retire_i,
   output logic [63:0] cycle_cnt_o,
   output logic [63:0] instret_cnt_o
);
   logic [63:0] cycle_q,   cycle_d;
   logic [63:0] instret_q, instret_d;

   always_comb begin
      cycle_d   = busy_i   ? cycle_q + 64'd1   : cycle_q;
      instret_d = retire_i ? instret_q + 64'd1 : instret_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycle_cnt_o   = cycle_q;
   assign instret_cnt_o = instret_q;
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM owning the PC and IR of the mspu core.
// Optional performance counters are built when CORE_SEQ_PERF_EN is defined.
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   core_seq_if.master        bus,
   output logic [31:0]       ir_o,
   input  logic              branch_en,
   input  logic              jal_en,
   input  logic              jalr_en,
   input  logic              mem_re,
   input  logic              mem_we,
   input  logic              reg_we,
   input  logic [4:0]        rd,
   input  logic [31:0]       imm,
   input  logic [31:0]       alu_result,
   output logic              rf_we,
   output logic [ADDR_W-1:0] pc_o,
   output logic              busy
`ifdef CORE_SEQ_PERF_EN
   ,
   output logic [63:0]       cycle_cnt,
   output logic [63:0]       instret_cnt
`endif
);
   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] npc_q, npc_d;
   logic [31:0]       ir_q, ir_d;

   logic              imem_req;
   logic              dmem_req;
   logic              dmem_we;

   logic [ADDR_W-1:0] jal_off;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] alu_addr;
   logic [ADDR_W-1:0] target_pc;
   logic              unused_imm;

   assign jal_off    = ADDR_W'($signed(imm[20:0]));
   assign br_off     = ADDR_W'($signed(imm[12:0]));
   assign alu_addr   = ADDR_W'(alu_result);
   assign unused_imm = ^imm[31:21];

   // jal outranks jalr, which outranks a taken branch.
   always_comb begin
      if (jal_en)
         target_pc = pc_q + jal_off;
      else if (jalr_en)
         target_pc = {alu_addr[ADDR_W-1:1], 1'b0};
      else if (branch_en && alu_result[0])
         target_pc = pc_q + br_off;
      else
         target_pc = pc_q + ADDR_W'(4);
   end

   always_comb begin
      // NOTE: every next-state value and output gets a default first, so no path leaves a latch behind.
      state_d  = state_q;
      pc_d     = pc_q;
      npc_d    = npc_q;
      ir_d     = ir_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = EXEC;
         end
         EXEC: begin
            npc_d   = target_pc;
            state_d = (mem_re || mem_we) ? MEM : WB;
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = mem_we;
            if (bus.dmem_ack) state_d = WB;
         end
         WB: begin
            rf_we   = reg_we && (rd != 5'd0);
            pc_d    = npc_q;
            state_d = run ? FETCH : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         npc_q   <= RESET_PC;
         ir_q    <= NOP_INSN;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         ir_q    <= ir_d;
      end
   end

   assign bus.imem_req  = imem_req;
   assign bus.imem_addr = pc_q;
   assign bus.dmem_req  = dmem_req;
   assign bus.dmem_we   = dmem_we;
   assign ir_o          = ir_q;
   assign pc_o          = pc_q;
   assign busy          = (state_q != IDLE);

`ifdef CORE_SEQ_PERF_EN
   core_seq_perf u_perf (
      .clk           (clk),
      .reset         (reset),
      .busy_i        (busy),
      .retire_i      (state_q == WB),
      .cycle_cnt_o   (cycle_cnt),
      .instret_cnt_o (instret_cnt)
   );
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// Randomized scoreboard bench for core_sequencer: a program table feeds a stub decoder and memories,
// and a monitor compares per-instruction timing, memory traffic, rf_we pulses and next PC to a reference model.
`timescale 1ns/1ps
module tb_core_sequencer;
   import core_seq_pkg::*;

   typedef struct packed {
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        mem_re;
      logic        mem_we;
      logic        reg_we;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] alu;
      logic [1:0]  imem_wait;
      logic [1:0]  dmem_wait;
   } desc_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] next_pc;
      bit          is_store;
      int          mem_cycles;
      int          rf_pulses;
      int          cycles;
   } exp_t;

   localparam logic [15:0] INSN_TAG = 16'hC0DE;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [31:0] ir;
   logic        branch_en, jal_en, jalr_en, mem_re, mem_we, reg_we;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic [31:0] alu_result;
   logic        rf_we;
   logic [31:0] pc;
   logic        busy;
`ifdef CORE_SEQ_PERF_EN
   logic [63:0] cycle_cnt;
   logic [63:0] instret_cnt;
`endif

   logic        imem_ack_r;
   logic        stray_ack;
   logic [31:0] imem_rdata_r;
   logic        dmem_ack_r;

   desc_t       prog [256];
   desc_t       cur_desc;
   int          prog_n;
   int          prog_len;
   int          fetch_cnt;
   logic [31:0] model_pc;
   exp_t        exp_q [$];
   bit          mon_en;

   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   core_seq_if #(.ADDR_W(32)) mif ();

   assign mif.imem_ack   = imem_ack_r | stray_ack;
   assign mif.imem_rdata = imem_rdata_r;
   assign mif.dmem_ack   = dmem_ack_r;

   core_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .bus         (mif.master),
      .ir_o        (ir),
      .branch_en   (branch_en),
      .jal_en      (jal_en),
      .jalr_en     (jalr_en),
      .mem_re      (mem_re),
      .mem_we      (mem_we),
      .reg_we      (reg_we),
      .rd          (rd),
      .imm         (imm),
      .alu_result  (alu_result),
      .rf_we       (rf_we),
      .pc_o        (pc),
      .busy        (busy)
`ifdef CORE_SEQ_PERF_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
`endif
   );

   // Stub decoder: tagged instruction words index the program table.
   always_comb begin
      cur_desc = '0;
      if (ir[31:16] == INSN_TAG) cur_desc = prog[ir[7:0]];
      branch_en  = cur_desc.branch;
      jal_en     = cur_desc.jal;
      jalr_en    = cur_desc.jalr;
      mem_re     = cur_desc.mem_re;
      mem_we     = cur_desc.mem_we;
      reg_we     = cur_desc.reg_we;
      rd         = cur_desc.rd;
      imm        = cur_desc.imm;
      alu_result = cur_desc.alu;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input desc_t d);
      longint off;
      if (d.jal) begin
         off = longint'(d.imm[20:0]);
         if (off >= 1048576) off = off - 2097152;
         return cur_pc + 32'(off);
      end
      if (d.jalr) return d.alu & 32'hFFFF_FFFE;
      if (d.branch && d.alu[0]) begin
         off = longint'(d.imm[12:0]);
         if (off >= 4096) off = off - 8192;
         return cur_pc + 32'(off);
      end
      return cur_pc + 32'd4;
   endfunction

   function automatic desc_t mk(input bit br, input bit jl, input bit jr, input bit re, input bit we,
                                input bit rwe, input logic [4:0] d_rd, input logic [31:0] d_imm,
                                input logic [31:0] d_alu, input logic [1:0] iw, input logic [1:0] dw);
      desc_t d;
      d = '0;
      d.branch = br; d.jal = jl; d.jalr = jr; d.mem_re = re; d.mem_we = we; d.reg_we = rwe;
      d.rd = d_rd; d.imm = d_imm; d.alu = d_alu; d.imem_wait = iw; d.dmem_wait = dw;
      return d;
   endfunction

   function automatic desc_t rand_desc();
      desc_t d;
      d = mk(0, 0, 0, 0, 0, 0, 5'($urandom), $urandom, $urandom,
             2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
      case ($urandom_range(0, 5))
         0:       d.reg_we = 1'b1;
         1:       begin d.mem_re = 1'b1; d.reg_we = 1'b1; end
         2:       d.mem_we = 1'b1;
         3:       d.branch = 1'b1;
         4:       begin d.jal = 1'b1; d.reg_we = 1'b1; end
         default: begin d.jalr = 1'b1; d.reg_we = 1'b1; end
      endcase
      // Occasionally stack several control-flow enables to exercise priority.
      if ($urandom_range(0, 5) == 0) begin
         d.jal    = d.jal    | 1'($urandom);
         d.jalr   = d.jalr   | 1'($urandom);
         d.branch = d.branch | 1'($urandom);
      end
      return d;
   endfunction

   task automatic add_insn(input desc_t d);
      exp_t e;
      e.pc         = model_pc;
      e.next_pc    = model_next(model_pc, d);
      e.is_store   = d.mem_we;
      e.mem_cycles = (d.mem_re || d.mem_we) ? 1 + int'(d.dmem_wait) : 0;
      e.rf_pulses  = (d.reg_we && d.rd != 5'd0) ? 1 : 0;
      e.cycles     = 4 + int'(d.imem_wait) + e.mem_cycles;
      prog[prog_n] = d;
      prog_n++;
      exp_q.push_back(e);
      model_pc = e.next_pc;
   endtask

   task automatic close_rec(input exp_t e, input int cyc, input int mc, input int rfc);
      check("insn_cycles",     64'(cyc), 64'(e.cycles));
      check("dmem_req_cycles", 64'(mc),  64'(e.mem_cycles));
      check("rf_we_pulses",    64'(rfc), 64'(e.rf_pulses));
      check("next_pc",         64'(pc),  64'(e.next_pc));
   endtask

   // Instruction memory: acknowledge after the programmed number of wait cycles.
   initial begin
      int iw;
      imem_ack_r   = 1'b0;
      imem_rdata_r = '0;
      fetch_cnt    = 0;
      iw           = 0;
      forever begin
         @(negedge clk);
         if (imem_ack_r) begin
            imem_ack_r = 1'b0;
            fetch_cnt++;
            iw = 0;
         end else if (mif.imem_req && fetch_cnt < prog_len) begin
            if (iw == int'(prog[fetch_cnt].imem_wait)) begin
               imem_ack_r   = 1'b1;
               imem_rdata_r = {INSN_TAG, 8'h00, 8'(fetch_cnt)};
            end else begin
               iw++;
            end
         end
      end
   end

   // Data memory: wait count comes from the most recently fetched instruction.
   initial begin
      int dw;
      dmem_ack_r = 1'b0;
      dw         = 0;
      forever begin
         @(negedge clk);
         if (dmem_ack_r) begin
            dmem_ack_r = 1'b0;
            dw = 0;
         end else if (mif.dmem_req) begin
            if (dw == int'(prog[8'(fetch_cnt - 1)].dmem_wait)) dmem_ack_r = 1'b1;
            else dw++;
         end
      end
   end

   // Monitor: one record per instruction, opened on each fetch start, closed at the next one or at idle.
   initial begin
      exp_t cur;
      bit   open;
      bit   prev_req;
      int   cyc, mc, rfc;
      open = 1'b0; prev_req = 1'b0; cyc = 0; mc = 0; rfc = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            open     = 1'b0;
            prev_req = mif.imem_req;
         end else begin
            if (mif.imem_req && !prev_req) begin
               if (open) close_rec(cur, cyc, mc, rfc);
               open = 1'b0;
               if (exp_q.size() == 0) begin
                  check("unexpected_fetch", 64'(mif.imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  cur  = exp_q.pop_front();
                  open = 1'b1;
                  cyc = 0; mc = 0; rfc = 0;
                  check("fetch_addr", 64'(mif.imem_addr), 64'(cur.pc));
               end
            end
            if (open && busy) begin
               cyc++;
               if (rf_we) rfc++;
               if (mif.dmem_req) begin
                  mc++;
                  check("dmem_we", 64'(mif.dmem_we), 64'(cur.is_store));
               end
            end
            if (open && !busy) begin
               close_rec(cur, cyc, mc, rfc);
               open = 1'b0;
            end
            prev_req = mif.imem_req;
         end
      end
   end

   initial begin
      bit ok;
      int extra;
      reset = 1'b1; run = 1'b0; stray_ack = 1'b0; mon_en = 1'b1;
      prog_n = 0; prog_len = 0; model_pc = 32'h0;

      add_insn(mk(0, 0, 0, 0, 0, 1, 5'd1, 32'h1,        32'h0,        2'd0, 2'd0)); // addi x1
      add_insn(mk(0, 1, 0, 0, 0, 1, 5'd1, 32'hFC,       32'h0,        2'd0, 2'd0)); // jal -> 0x100
      add_insn(mk(1, 0, 0, 0, 0, 0, 5'd3, 32'h1FF8,     32'h1,        2'd1, 2'd0)); // beq taken -> 0xF8
      add_insn(mk(0, 1, 0, 0, 0, 0, 5'd0, 32'h8,        32'h0,        2'd0, 2'd0)); // jal -> 0x100
      add_insn(mk(1, 0, 0, 0, 0, 0, 5'd3, 32'h1FF8,     32'h0,        2'd0, 2'd0)); // beq not taken -> 0x104
      add_insn(mk(0, 0, 1, 0, 0, 1, 5'd2, 32'h0,        32'h203,      2'd0, 2'd0)); // jalr -> 0x202
      add_insn(mk(0, 0, 1, 0, 0, 1, 5'd2, 32'h0,        32'h9,        2'd0, 2'd0)); // jalr -> 0x8
      add_insn(mk(0, 1, 0, 0, 0, 1, 5'd1, 32'h1FFFFC,   32'h0,        2'd0, 2'd0)); // jal -> 0x4
      add_insn(mk(0, 0, 0, 1, 0, 1, 5'd5, 32'h0,        32'h40,       2'd0, 2'd3)); // lb, 3 wait cycles
      add_insn(mk(0, 0, 0, 0, 1, 0, 5'd6, 32'h0,        32'h44,       2'd0, 2'd1)); // sb
      add_insn(mk(0, 0, 0, 0, 0, 1, 5'd0, 32'h5,        32'h0,        2'd2, 2'd0)); // addi x0
      for (int i = 0; i < 40; i++) add_insn(rand_desc());
      add_insn(mk(0, 0, 0, 1, 0, 1, 5'd7, 32'h0,        32'h80,       2'd0, 2'd2)); // last: lb

      repeat (3) @(negedge clk);
      check("reset_busy",     64'(busy),         64'h0);
      check("reset_imem_req", 64'(mif.imem_req), 64'h0);
      check("reset_dmem_req", 64'(mif.dmem_req), 64'h0);
      check("reset_rf_we",    64'(rf_we),        64'h0);
      check("reset_pc",       64'(pc),           64'h0);
      check("reset_ir",       64'(ir),           64'(NOP_INSN));

      reset = 1'b0;
      @(negedge clk);
      prog_len = prog_n;
      run      = 1'b1;
      @(negedge clk);
      check("first_fetch_req", 64'(mif.imem_req), 64'h1);

      // Drop run while the last instruction sits in MEM.
      ok = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (fetch_cnt == prog_len && mif.dmem_req) begin
            ok = 1'b1;
            break;
         end
      end
      check("reach_last_mem", 64'(ok), 64'h1);
      run = 1'b0;
      ok  = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_after_run_drop", 64'(ok), 64'h1);
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (mif.imem_req || busy) extra++;
      end
      check("no_fetch_after_stop", 64'(extra),        64'h0);
      check("fetch_count",         64'(fetch_cnt),    64'(prog_len));
      check("scoreboard_drained",  64'(exp_q.size()), 64'h0);

      // Reset while a fetch is stalled, then a stray acknowledge.
      mon_en = 1'b0;
      run    = 1'b1;
      ok     = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (mif.imem_req) begin
            ok = 1'b1;
            break;
         end
      end
      check("stalled_fetch_req",  64'(ok),            64'h1);
      check("stalled_fetch_addr", 64'(mif.imem_addr), 64'(model_pc));
      @(negedge clk);
      reset = 1'b1;
      run   = 1'b0;
      @(negedge clk);
      check("req_drop_after_reset", 64'(mif.imem_req), 64'h0);
      reset     = 1'b0;
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_busy",     64'(busy),         64'h0);
      check("post_reset_imem_req", 64'(mif.imem_req), 64'h0);
      check("post_reset_pc",       64'(pc),           64'h0);
      check("post_reset_ir",       64'(ir),           64'(NOP_INSN));

      // Ten back-to-back zero-wait addi from run=1.
      model_pc = 32'h0;
      for (int i = 0; i < 10; i++) add_insn(mk(0, 0, 0, 0, 0, 1, 5'(i + 1), 32'h1, 32'h0, 2'd0, 2'd0));
      mon_en   = 1'b1;
      prog_len = prog_n;
      run      = 1'b1;
      ok       = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (fetch_cnt == prog_len) begin
            ok = 1'b1;
            break;
         end
      end
      check("addi_burst_fetched", 64'(ok), 64'h1);
      run = 1'b0;
      ok  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("addi_burst_idle",       64'(ok),           64'h1);
      check("addi_burst_drained",    64'(exp_q.size()), 64'h0);
      check("addi_burst_final_pc",   64'(pc),           64'h28);
`ifdef CORE_SEQ_PERF_EN
      check("perf_instret_cnt", instret_cnt, 64'd10);
      check("perf_cycle_cnt",   cycle_cnt,   64'd40);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks made", n_checks);
      $fatal(1, "watchdog expired");
   end
endmodule
